// File: rtl/xor_shift_draw.sv
// Xorshift pseudo-random source with bounded on-demand draws.
// The state register steps every clock. A draw request is answered with a
// value in [0, limit-1] using mask-and-reject sampling. After MAX_TRIES
// consecutive rejections a folded fallback value is returned and flagged.
module xor_shift_draw #(
   parameter int          WIDTH        = 32,
   parameter int          SHIFT_A      = 7,
   parameter int          SHIFT_B      = 9,
   parameter int          SHIFT_C      = 13,
   parameter int          OUT_W        = 4,
   parameter int          MAX_TRIES    = 8,
   parameter logic [31:0] DEFAULT_SEED = 32'hDEADBEEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] seed,
   input  logic             seed_load,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OUT_W:0]   req_limit,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic [OUT_W-1:0] rnd_data,
   output logic             rnd_fallback,
   output logic [WIDTH-1:0] raw_rand
);

   localparam int               CNT_W     = $clog2(MAX_TRIES + 1);
   localparam logic [WIDTH-1:0] SEED_DFLT = WIDTH'(DEFAULT_SEED);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Generator state
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] w_seedz;
   logic [WIDTH-1:0] w_t1;
   logic [WIDTH-1:0] w_t2;
   logic [WIDTH-1:0] w_t3;

   // Draw controller state
   state_t           r_state;
   state_t           w_state_next;
   logic [OUT_W:0]   r_limit;
   logic [OUT_W:0]   w_limit_next;
   logic [OUT_W-1:0] r_mask;
   logic [OUT_W-1:0] w_mask_next;
   logic [CNT_W-1:0] r_tries;
   logic [CNT_W-1:0] w_tries_next;
   logic [OUT_W-1:0] r_data;
   logic [OUT_W-1:0] w_data_next;
   logic             r_fb;
   logic             w_fb_next;

   // Request decode and candidate evaluation
   logic [OUT_W:0]   w_lim_in;
   logic [OUT_W-1:0] w_lim_m1;
   logic [OUT_W-1:0] w_smear [0:OUT_W-1];
   logic [OUT_W-1:0] w_mask_in;
   logic [OUT_W-1:0] w_cand;
   logic             w_accept;
   logic [CNT_W-1:0] w_tries_inc;
   logic             w_exhaust;
   logic [OUT_W-1:0] w_fold;
   logic             w_req_ready;
   logic             w_rnd_valid;

   // Zero seed would lock the generator at zero, so it is replaced.
   assign w_seedz = (seed == '0) ? SEED_DFLT : seed;

   // One xorshift step from the registered state
   always_comb begin
      w_t1 = r_s ^ (r_s >> SHIFT_A);
      w_t2 = w_t1 ^ (w_t1 << SHIFT_B);
      w_t3 = w_t2 ^ (w_t2 >> SHIFT_C);
   end

   // A limit of 0 behaves like 1 so the only legal result is 0.
   assign w_lim_in = (req_limit == '0) ? (OUT_W+1)'(1) : req_limit;
   assign w_lim_m1 = OUT_W'(w_lim_in - (OUT_W+1)'(1));

   // Smear the top set bit of limit-1 downward to form the 2^k-1 mask.
   assign w_smear[0] = w_lim_m1;
   generate
      for (genvar gi = 1; gi < OUT_W; gi++) begin : g_smear
         assign w_smear[gi] = w_smear[gi-1] | (w_smear[gi-1] >> gi);
      end
   endgenerate
   assign w_mask_in = w_smear[OUT_W-1];

   // Candidate uses the state register of the current DRAW cycle.
   assign w_cand      = r_s[OUT_W-1:0] & r_mask;
   assign w_accept    = ({1'b0, w_cand} < r_limit);
   assign w_tries_inc = r_tries + CNT_W'(1);
   assign w_exhaust   = (w_tries_inc == CNT_W'(MAX_TRIES));
   // A rejected candidate is at most 2L-2, so cand-L always lands below L.
   assign w_fold      = w_cand - r_limit[OUT_W-1:0];

   // Generator register: reset and reseed both load the protected seed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s <= w_seedz;
      end else if (seed_load) begin
         r_s <= w_seedz;
      end else begin
         r_s <= w_t3;
      end
   end

   // Draw FSM next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      w_limit_next = r_limit;
      w_mask_next  = r_mask;
      w_tries_next = r_tries;
      w_data_next  = r_data;
      w_fb_next    = r_fb;
      w_req_ready  = 1'b0;
      w_rnd_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = 1'b1;
            if (req_valid) begin
               w_limit_next = w_lim_in;
               w_mask_next  = w_mask_in;
               w_tries_next = '0;
               w_state_next = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (w_accept) begin
               w_data_next  = w_cand;
               w_fb_next    = 1'b0;
               w_state_next = ST_DONE;
            end else begin
               w_tries_next = w_tries_inc;
               if (w_exhaust) begin
                  w_data_next  = w_fold;
                  w_fb_next    = 1'b1;
                  w_state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            w_rnd_valid = 1'b1;
            if (rnd_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Draw FSM registers; reset discards any pending result.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_limit <= '0;
         r_mask  <= '0;
         r_tries <= '0;
         r_data  <= '0;
         r_fb    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_limit <= w_limit_next;
         r_mask  <= w_mask_next;
         r_tries <= w_tries_next;
         r_data  <= w_data_next;
         r_fb    <= w_fb_next;
      end
   end

   assign req_ready    = w_req_ready;
   assign rnd_valid    = w_rnd_valid;
   assign rnd_data     = r_data;
   assign rnd_fallback = r_fb;
   assign raw_rand     = r_s;

endmodule

// File: tb/tb_xor_shift_draw.sv
// Directed and model-based checks for xor_shift_draw.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_xor_shift_draw;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] seed;
   logic        seed_load;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_limit;
   logic        rnd_valid;
   logic        rnd_ready;
   logic [3:0]  rnd_data;
   logic        rnd_fallback;
   logic [31:0] raw_rand;

   logic [31:0] seed2;
   logic        seed_load2;
   logic        req_valid2;
   logic        req_ready2;
   logic [4:0]  req_limit2;
   logic        rnd_valid2;
   logic        rnd_ready2;
   logic [3:0]  rnd_data2;
   logic        rnd_fallback2;
   logic [31:0] raw_rand2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   xor_shift_draw dut (
      .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load),
      .req_valid(req_valid), .req_ready(req_ready), .req_limit(req_limit),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
      .rnd_fallback(rnd_fallback), .raw_rand(raw_rand)
   );

   xor_shift_draw #(.MAX_TRIES(2)) dut2 (
      .clk(clk), .rst(rst), .seed(seed2), .seed_load(seed_load2),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_limit(req_limit2),
      .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2), .rnd_data(rnd_data2),
      .rnd_fallback(rnd_fallback2), .raw_rand(raw_rand2)
   );

   function automatic logic [31:0] step(input logic [31:0] s);
      logic [31:0] a, b;
      a = s ^ (s >> 7);
      b = a ^ (a << 9);
      return b ^ (b >> 13);
   endfunction

   function automatic logic [31:0] seedz(input logic [31:0] v);
      return (v == 32'h0) ? 32'hDEADBEEF : v;
   endfunction

   function automatic logic [3:0] mask_of(input int l);
      int k = 0;
      while (((1 << k) - 1) < (l - 1)) k++;
      return 4'((1 << k) - 1);
   endfunction

   // Reference generator state for the default instance
   logic [31:0] m_s;
   always @(posedge clk) begin
      if (!rst || seed_load) m_s <= seedz(seed);
      else                   m_s <= step(m_s);
   end

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b0; seed = 32'h1;
      @(negedge clk);
      @(negedge clk);
      total++; if (raw_rand !== 32'h1) begin bad++; $display("FAIL reset_raw0: got %h want 00000001", raw_rand); end
      total++; if (req_ready !== 1'b1 || rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_hs: ready=%b valid=%b want 1/0", req_ready, rnd_valid); end
      total++; if (rnd_data !== 4'd0 || rnd_fallback !== 1'b0) begin bad++; $display("FAIL reset_data: data=%0d fb=%b want 0/0", rnd_data, rnd_fallback); end
      total++; if (req_ready2 !== 1'b1 || rnd_valid2 !== 1'b0) begin bad++; $display("FAIL reset_hs2: ready=%b valid=%b want 1/0", req_ready2, rnd_valid2); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (raw_rand !== 32'h00000201) begin bad++; $display("FAIL reset_raw1: got %h want 00000201", raw_rand); end
      @(negedge clk);
      total++; if (raw_rand !== 32'h00040825) begin bad++; $display("FAIL reset_raw2: got %h want 00040825", raw_rand); end
      $display("reset: raw sequence checked");
   endtask

   task automatic test_zero_seed;
      @(negedge clk);
      seed = 32'h0; rst = 1'b0;
      @(negedge clk);
      total++; if (raw_rand !== 32'hDEADBEEF) begin bad++; $display("FAIL zero_seed_reset: got %h want deadbeef", raw_rand); end
      rst = 1'b1; seed = 32'h55;
      @(negedge clk);
      total++; if (raw_rand !== step(32'hDEADBEEF)) begin bad++; $display("FAIL zero_seed_step: got %h want %h", raw_rand, step(32'hDEADBEEF)); end
      @(negedge clk);
      seed = 32'h0; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      total++; if (raw_rand !== 32'hDEADBEEF) begin bad++; $display("FAIL zero_seed_load: got %h want deadbeef", raw_rand); end
      $display("zero_seed: reset and reload substitute default");
   endtask

   task automatic test_seed_with_request;
      @(negedge clk);
      seed = 32'h1; seed_load = 1'b1; req_valid = 1'b1; req_limit = 5'd4; rnd_ready = 1'b0;
      @(negedge clk);
      seed_load = 1'b0; req_valid = 1'b0;
      total++; if (rnd_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL seedreq_draw: valid=%b ready=%b want 0/0", rnd_valid, req_ready); end
      @(negedge clk);
      total++; if (rnd_valid !== 1'b1 || rnd_data !== 4'd1 || rnd_fallback !== 1'b0) begin bad++; $display("FAIL seedreq_result: valid=%b data=%0d fb=%b want 1/1/0", rnd_valid, rnd_data, rnd_fallback); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (rnd_valid !== 1'b1 || rnd_data !== 4'd1 || req_ready !== 1'b0) begin bad++; $display("FAIL seedreq_hold%0d: valid=%b data=%0d ready=%b want 1/1/0", i, rnd_valid, rnd_data, req_ready); end
      end
      rnd_ready = 1'b1;
      @(negedge clk);
      rnd_ready = 1'b0;
      total++; if (rnd_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL seedreq_release: valid=%b ready=%b want 0/1", rnd_valid, req_ready); end
      $display("seed_with_request: data=%0d fb=%b", rnd_data, rnd_fallback);
   endtask

   task automatic test_fallback;
      @(negedge clk);
      seed2 = 32'h3; seed_load2 = 1'b1; req_valid2 = 1'b1; req_limit2 = 5'd3; rnd_ready2 = 1'b0;
      @(negedge clk);
      seed_load2 = 1'b0; req_valid2 = 1'b0;
      total++; if (rnd_valid2 !== 1'b0 || raw_rand2 !== 32'h3) begin bad++; $display("FAIL fb_try1: valid=%b raw=%h want 0/00000003", rnd_valid2, raw_rand2); end
      @(negedge clk);
      total++; if (rnd_valid2 !== 1'b0 || raw_rand2 !== 32'h603) begin bad++; $display("FAIL fb_try2: valid=%b raw=%h want 0/00000603", rnd_valid2, raw_rand2); end
      @(negedge clk);
      total++; if (rnd_valid2 !== 1'b1 || rnd_data2 !== 4'd0 || rnd_fallback2 !== 1'b1) begin bad++; $display("FAIL fb_result: valid=%b data=%0d fb=%b want 1/0/1", rnd_valid2, rnd_data2, rnd_fallback2); end
      rnd_ready2 = 1'b1;
      @(negedge clk);
      rnd_ready2 = 1'b0;
      total++; if (req_ready2 !== 1'b1 || rnd_valid2 !== 1'b0) begin bad++; $display("FAIL fb_release: ready=%b valid=%b want 1/0", req_ready2, rnd_valid2); end
      $display("fallback: data=%0d fb=%b", rnd_data2, rnd_fallback2);
   endtask

   task automatic test_limit_zero_one;
      for (int lim = 0; lim < 2; lim++) begin
         @(negedge clk);
         req_limit = 5'(lim); req_valid = 1'b1; rnd_ready = 1'b0;
         @(negedge clk);
         req_valid = 1'b0;
         total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL lim%0d_draw: valid=%b want 0", lim, rnd_valid); end
         @(negedge clk);
         total++; if (rnd_valid !== 1'b1 || rnd_data !== 4'd0 || rnd_fallback !== 1'b0) begin bad++; $display("FAIL lim%0d_result: valid=%b data=%0d fb=%b want 1/0/0", lim, rnd_valid, rnd_data, rnd_fallback); end
         rnd_ready = 1'b1;
         @(negedge clk);
         rnd_ready = 1'b0;
         total++; if (rnd_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL lim%0d_release: valid=%b ready=%b want 0/1", lim, rnd_valid, req_ready); end
         $display("limit %0d: data=%0d", lim, rnd_data);
      end
   endtask

   task automatic test_regression;
      int          L, tries, cyc;
      bit          done, exp_fb;
      logic [3:0]  mask, cand, exp_d;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reg%0d_idle: ready=%b want 1", n, req_ready); end
         L = $urandom_range(1, 16);
         req_limit = 5'(L); req_valid = 1'b1; rnd_ready = 1'b0;
         if (n % 40 == 7) begin seed = $urandom; seed_load = 1'b1; end
         @(negedge clk);
         req_valid = 1'b0; seed_load = 1'b0;
         mask = mask_of(L); tries = 0; cyc = 0; done = 1'b0; exp_d = 4'd0; exp_fb = 1'b0;
         while (!done && cyc < 12) begin
            total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reg%0d_early: valid=%b at cycle %0d want 0", n, rnd_valid, cyc); end
            cand = m_s[3:0] & mask;
            if (int'(cand) < L) begin
               exp_d = cand; exp_fb = 1'b0; done = 1'b1;
            end else begin
               tries++;
               if (tries == 8) begin exp_d = 4'(int'(cand) - L); exp_fb = 1'b1; done = 1'b1; end
            end
            if (n % 50 == 25 && cyc == 0) begin seed = (n % 100 == 25) ? 32'h0 : $urandom; seed_load = 1'b1; end
            @(negedge clk);
            seed_load = 1'b0;
            cyc++;
         end
         total++; if (!done) begin bad++; $display("FAIL reg%0d_bound: model did not finish within %0d cycles", n, cyc); end
         total++; if (rnd_valid !== 1'b1 || rnd_data !== exp_d || rnd_fallback !== exp_fb) begin bad++; $display("FAIL reg%0d_result: limit=%0d valid=%b data=%0d fb=%b want 1/%0d/%b", n, L, rnd_valid, rnd_data, rnd_fallback, exp_d, exp_fb); end
         total++; if (!(int'(rnd_data) < L)) begin bad++; $display("FAIL reg%0d_range: data=%0d want below %0d", n, rnd_data, L); end
         $display("draw %0d: limit=%0d data=%0d fb=%b cycles=%0d", n, L, rnd_data, rnd_fallback, cyc);
         rnd_ready = 1'b1;
         @(negedge clk);
         rnd_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid_draw;
      @(negedge clk);
      seed = 32'h1; seed_load = 1'b1; req_valid = 1'b1; req_limit = 5'd4; rnd_ready = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      total++; if (rnd_valid !== 1'b1 || rnd_data !== 4'd1) begin bad++; $display("FAIL midrst_pre: valid=%b data=%0d want 1/1", rnd_valid, rnd_data); end
      @(negedge clk);
      rnd_ready = 1'b0;
      req_limit = 5'd16; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL midrst_indraw: ready=%b want 0", req_ready); end
      @(negedge clk);
      total++; if (rnd_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL midrst_hs: valid=%b ready=%b want 0/1", rnd_valid, req_ready); end
      total++; if (rnd_data !== 4'd0 || rnd_fallback !== 1'b0) begin bad++; $display("FAIL midrst_data: data=%0d fb=%b want 0/0", rnd_data, rnd_fallback); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (rnd_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL midrst_after: valid=%b ready=%b want 0/1", rnd_valid, req_ready); end
      $display("reset_mid_draw: pending draw discarded");
   endtask

   initial begin
      rst = 1'b0; seed = 32'h1; seed_load = 1'b0; req_valid = 1'b0; req_limit = 5'd0; rnd_ready = 1'b0;
      seed2 = 32'h0; seed_load2 = 1'b0; req_valid2 = 1'b0; req_limit2 = 5'd0; rnd_ready2 = 1'b0;
      test_reset();
      test_zero_seed();
      test_seed_with_request();
      test_fallback();
      test_limit_zero_one();
      test_regression();
      test_reset_mid_draw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
